// File: rtl/perf_cnt_pkg.sv
// Shared constants and types for the performance counter bank.
// Holds the register-window offsets (relative to BASE_ADDR), the channel
// limit and the MMIO write payload type.
// Optional feature macro used by the bank: PERF_CNT_SNAPSHOT_EN.
package perf_cnt_pkg;

    localparam int unsigned MAX_CNT = 8;

    localparam logic [31:0] OFF_CTRL     = 32'h0000_0000;
    localparam logic [31:0] OFF_OVF      = 32'h0000_0004;
    localparam logic [31:0] OFF_CLR_ALL  = 32'h0000_0008;
    localparam logic [31:0] OFF_CLR_MASK = 32'h0000_000C;
    localparam logic [31:0] OFF_SNAP     = 32'h0000_0010;
    localparam logic [31:0] OFF_CNT      = 32'h0000_0020;
    localparam logic [31:0] OFF_LIVE     = 32'h0000_0060;

    typedef struct packed {
        logic [3:0]  wbe;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mmio_wr_t;

    // Offset of channel idx inside a per-channel window starting at win.
    function automatic logic [31:0] chan_off(input logic [31:0] win, input int unsigned idx);
        return win + 32'(idx * 4);
    endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// One event counter channel with clear, increment and wrap/saturate handling.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   en           - global count enable
//   clr          - synchronous clear, beats increment
//   inc          - increment request for this cycle
//   cnt_o        - current count (direct from flops)
//   ovf_set_c    - combinational pulse: an increment hit all-ones this cycle
module perf_counter_cell
    import perf_cnt_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_set_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear first, then increment with wrap or saturate at all-ones.
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_c = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en && inc) begin
            if (&cnt_q) begin
                ovf_set_c = 1'b1;
                cnt_d     = SATURATE ? cnt_q : '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CNT memory-mapped event counters on the MMIO path.
// Register window at BASE_ADDR: CTRL (enable), OVF (sticky, W1C), CLEAR_ALL,
// CLEAR_MASK, SNAP, counters at 0x20+4*i (and live view at 0x60+4*i when
// snapshots are built in).
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   wbe      - byte write enables, any set bit means a write
//   addr     - write address
//   wdata    - write data
//   rd_addr  - read address
//   rd_data  - registered read data, one cycle after rd_addr
//   event_i  - per-channel increment requests
//   ovf_o    - sticky overflow flags
// Optional feature: define PERF_CNT_SNAPSHOT_EN for SNAP shadow registers.
module perf_counter_bank
    import perf_cnt_pkg::*;
#(
    parameter int unsigned NUM_CNT   = 4,
    parameter int unsigned CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0010,
    parameter bit          SATURATE  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         wbe,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [31:0]        rd_addr,
    output logic [31:0]        rd_data,
    input  logic [NUM_CNT-1:0] event_i,
    output logic [NUM_CNT-1:0] ovf_o
);

    mmio_wr_t wr_req;
    logic     wr_any;
    logic [31:0] wr_off;
    logic [31:0] rd_off;

    logic wr_ctrl;
    logic wr_ovf;
    logic wr_clr_all;
    logic wr_clr_mask;

    logic               en_q;
    logic               en_d;
    logic [NUM_CNT-1:0] ovf_q;
    logic [NUM_CNT-1:0] ovf_d;
    logic [31:0]        rd_data_q;
    logic [31:0]        rd_data_d;

    logic [NUM_CNT-1:0] clr_vec;
    logic [NUM_CNT-1:0] ovf_set;
    logic [CNT_W-1:0]   cnt [NUM_CNT];

    // Low address bits and the high wdata bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{wr_req.wdata, wr_req.addr[1:0], rd_addr[1:0]};

    // Write decode on word-aligned offsets.
    assign wr_req      = '{wbe: wbe, addr: addr, wdata: wdata};
    assign wr_any      = |wr_req.wbe;
    assign wr_off      = {wr_req.addr[31:2], 2'b00} - BASE_ADDR;
    assign rd_off      = {rd_addr[31:2], 2'b00} - BASE_ADDR;
    assign wr_ctrl     = wr_any && (wr_off == OFF_CTRL) && wr_req.wbe[0];
    assign wr_ovf      = wr_any && (wr_off == OFF_OVF);
    assign wr_clr_all  = wr_any && (wr_off == OFF_CLR_ALL);
    assign wr_clr_mask = wr_any && (wr_off == OFF_CLR_MASK);

    // Per-channel clear requests from CLEAR_ALL and CLEAR_MASK.
    always_comb begin
        clr_vec = '0;
        if (wr_clr_all) begin
            clr_vec = '1;
        end
        if (wr_clr_mask) begin
            clr_vec = clr_vec | wr_req.wdata[NUM_CNT-1:0];
        end
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cell
        perf_counter_cell #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .en        (en_q),
            .clr       (clr_vec[g]),
            .inc       (event_i[g]),
            .cnt_o     (cnt[g]),
            .ovf_set_c (ovf_set[g])
        );
    end

`ifdef PERF_CNT_SNAPSHOT_EN
    logic             wr_snap;
    logic [CNT_W-1:0] shadow_q [NUM_CNT];
    logic [CNT_W-1:0] shadow_d [NUM_CNT];

    assign wr_snap = wr_any && (wr_off == OFF_SNAP);

    // Shadows capture the pre-increment counts on a SNAP write.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_snap) begin
            shadow_d = cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CNT; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    // CTRL enable and sticky overflow; a new overflow beats W1C on the same bit.
    always_comb begin
        en_d  = en_q;
        ovf_d = ovf_q;
        if (wr_ctrl) begin
            en_d = wr_req.wdata[0];
        end
        if (wr_ovf) begin
            ovf_d = ovf_d & ~wr_req.wdata[NUM_CNT-1:0];
        end
        ovf_d = ovf_d | ovf_set;
    end

    // Read mux over current flop values, so a same-cycle write is not visible.
    always_comb begin
        rd_data_d = '0;
        if (rd_off == OFF_CTRL) begin
            rd_data_d = {31'b0, en_q};
        end
        if (rd_off == OFF_OVF) begin
            rd_data_d = 32'(ovf_q);
        end
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
`ifdef PERF_CNT_SNAPSHOT_EN
            if (rd_off == chan_off(OFF_CNT, i)) begin
                rd_data_d = 32'(shadow_q[i]);
            end
            if (rd_off == chan_off(OFF_LIVE, i)) begin
                rd_data_d = 32'(cnt[i]);
            end
`else
            if (rd_off == chan_off(OFF_CNT, i)) begin
                rd_data_d = 32'(cnt[i]);
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q      <= 1'b1;
            ovf_q     <= '0;
            rd_data_q <= '0;
        end else begin
            en_q      <= en_d;
            ovf_q     <= ovf_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 32-bit wrap bank plus two 4-bit
// banks (wrap and saturate) sharing the same stimulus.
module tb_perf_counter_bank;

    localparam logic [31:0] B         = 32'h8000_0010;
    localparam logic [31:0] A_CTRL    = B + 32'h00;
    localparam logic [31:0] A_OVF     = B + 32'h04;
    localparam logic [31:0] A_CLRALL  = B + 32'h08;
    localparam logic [31:0] A_CLRMASK = B + 32'h0C;
    localparam logic [31:0] A_SNAP    = B + 32'h10;
    localparam logic [31:0] A_CNT0    = B + 32'h20;
    localparam logic [31:0] A_LIVE0   = B + 32'h60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  wbe = 4'h0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rd_addr = '0;
    logic [3:0]  event_i = '0;
    logic [31:0] rd_data, rd_data_w, rd_data_s;
    logic [3:0]  ovf_o, ovf_w, ovf_s;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CNT(4), .CNT_W(32), .BASE_ADDR(B), .SATURATE(1'b0)) dut (
        .clk(clk), .rst(rst), .wbe(wbe), .addr(addr), .wdata(wdata),
        .rd_addr(rd_addr), .rd_data(rd_data), .event_i(event_i), .ovf_o(ovf_o));

    perf_counter_bank #(.NUM_CNT(4), .CNT_W(4), .BASE_ADDR(B), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .wbe(wbe), .addr(addr), .wdata(wdata),
        .rd_addr(rd_addr), .rd_data(rd_data_w), .event_i(event_i), .ovf_o(ovf_w));

    perf_counter_bank #(.NUM_CNT(4), .CNT_W(4), .BASE_ADDR(B), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .wbe(wbe), .addr(addr), .wdata(wdata),
        .rd_addr(rd_addr), .rd_data(rd_data_s), .event_i(event_i), .ovf_o(ovf_s));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wbe = 4'hf; addr = a; wdata = d;
        tick(1);
        wbe = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a);
        rd_addr = a;
        tick(1);
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL reset_rd_data got %0h want 0", rd_data); else n_pass++;
        n_checks++; if (ovf_o !== 4'd0) $display("FAIL reset_ovf got %0h want 0", ovf_o); else n_pass++;
        n_checks++; if (ovf_s !== 4'd0 || rd_data_w !== 32'd0) $display("FAIL reset_small got ovf_s=%0h rd_w=%0h want 0/0", ovf_s, rd_data_w); else n_pass++;
        rst = 1'b0;
        rd(A_CTRL);
        n_checks++; if (rd_data !== 32'd1) $display("FAIL reset_ctrl got %0h want 1", rd_data); else n_pass++;
        rd(A_OVF);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL reset_ovf_reg got %0h want 0", rd_data); else n_pass++;
    endtask

    task automatic test_cycle_count();
        event_i = 4'b0001; rd_addr = A_CNT0; rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL cyc_latency got %0d want 0", rd_data); else n_pass++;
        tick(10);
        n_checks++; if (rd_data !== 32'd10) $display("FAIL cyc_count10 got %0d want 10", rd_data); else n_pass++;
        tick(1);
        n_checks++; if (rd_data !== 32'd11) $display("FAIL cyc_count11 got %0d want 11", rd_data); else n_pass++;
    endtask

    task automatic test_legacy_clear();
        // cnt0 is 12 here; the clear edge still returns the pre-clear value.
        wbe = 4'hf; addr = 32'h8000_0018; wdata = 32'hffff_ffff;
        tick(1);
        wbe = 4'h0;
        n_checks++; if (rd_data !== 32'd12) $display("FAIL clr_prewrite got %0d want 12", rd_data); else n_pass++;
        tick(1);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL clr_zero got %0d want 0", rd_data); else n_pass++;
        tick(1);
        n_checks++; if (rd_data !== 32'd1) $display("FAIL clr_one got %0d want 1", rd_data); else n_pass++;
        tick(1);
        n_checks++; if (rd_data !== 32'd2) $display("FAIL clr_two got %0d want 2", rd_data); else n_pass++;
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        #1;
        n_checks++; if (rd_data !== 32'd0) $display("FAIL async_rst_rd got %0h want 0", rd_data); else n_pass++;
        tick(1);
        event_i = 4'b0000;
        rst = 1'b0;
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL async_rst_cnt got %0d want 0", rd_data); else n_pass++;
    endtask

    task automatic test_clear_vs_inc();
        event_i = 4'b0111;
        tick(5);
        wbe = 4'hf; addr = A_CLRMASK; wdata = 32'h2;
        tick(1);
        wbe = 4'h0; event_i = 4'b0000;
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd6) $display("FAIL mask_cnt0 got %0d want 6", rd_data); else n_pass++;
        rd(A_CNT0 + 32'h4);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL mask_cnt1 got %0d want 0", rd_data); else n_pass++;
        rd(A_CNT0 + 32'h8);
        n_checks++; if (rd_data !== 32'd6) $display("FAIL mask_cnt2 got %0d want 6", rd_data); else n_pass++;
        rd(A_CNT0 + 32'hC);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL mask_cnt3 got %0d want 0", rd_data); else n_pass++;
        rd(A_CNT0 + 32'h10);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL unmapped_ch4 got %0d want 0", rd_data); else n_pass++;
        rd(A_SNAP);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL snap_reg_read got %0d want 0", rd_data); else n_pass++;
        rd(A_CNT0 + 32'h3);
        n_checks++; if (rd_data !== 32'd6) $display("FAIL misaligned_rd got %0d want 6", rd_data); else n_pass++;
    endtask

    task automatic test_freeze();
        wbe = 4'h1; addr = A_CTRL; wdata = 32'h0; rd_addr = A_CTRL;
        tick(1);
        wbe = 4'h0;
        n_checks++; if (rd_data !== 32'd1) $display("FAIL ctrl_prewrite got %0d want 1", rd_data); else n_pass++;
        event_i = 4'hf;
        tick(5);
        rd(A_CTRL);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL ctrl_off got %0d want 0", rd_data); else n_pass++;
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd6) $display("FAIL frozen_cnt0 got %0d want 6", rd_data); else n_pass++;
        rd(A_CNT0 + 32'hC);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL frozen_cnt3 got %0d want 0", rd_data); else n_pass++;
        wr(A_CLRMASK, 32'h1);
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL frozen_clear got %0d want 0", rd_data); else n_pass++;
        wbe = 4'b0010; addr = A_CTRL; wdata = 32'h1;
        tick(1);
        wbe = 4'h0;
        rd(A_CTRL);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL ctrl_wbe0_gate got %0d want 0", rd_data); else n_pass++;
        wbe = 4'h1; addr = A_CTRL; wdata = 32'h1;
        tick(1);
        wbe = 4'h0;
        tick(3);
        event_i = 4'h0;
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd3) $display("FAIL resume_cnt0 got %0d want 3", rd_data); else n_pass++;
        rd(A_CNT0 + 32'h8);
        n_checks++; if (rd_data !== 32'd9) $display("FAIL resume_cnt2 got %0d want 9", rd_data); else n_pass++;
        wr(A_CNT0, 32'h55);
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd3) $display("FAIL cnt_readonly got %0d want 3", rd_data); else n_pass++;
    endtask

    task automatic test_overflow();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        event_i = 4'b0001;
        tick(15);
        n_checks++; if (ovf_w !== 4'd0 || ovf_s !== 4'd0) $display("FAIL ovf_at_max got w=%0h s=%0h want 0/0", ovf_w, ovf_s); else n_pass++;
        tick(1);
        n_checks++; if (ovf_w !== 4'b0001) $display("FAIL ovf_wrap_set got %0h want 1", ovf_w); else n_pass++;
        n_checks++; if (ovf_s !== 4'b0001) $display("FAIL ovf_sat_set got %0h want 1", ovf_s); else n_pass++;
        tick(4);
        event_i = 4'b0000;
        rd(A_CNT0);
        n_checks++; if (rd_data_w !== 32'd4) $display("FAIL wrap_cnt got %0d want 4", rd_data_w); else n_pass++;
        n_checks++; if (rd_data_s !== 32'd15) $display("FAIL sat_cnt got %0d want 15", rd_data_s); else n_pass++;
        n_checks++; if (rd_data !== 32'd20 || ovf_o !== 4'd0) $display("FAIL wide_cnt got %0d ovf %0h want 20/0", rd_data, ovf_o); else n_pass++;
        rd(A_OVF);
        n_checks++; if (rd_data_w !== 32'd1 || rd_data_s !== 32'd1) $display("FAIL ovf_reg got w=%0h s=%0h want 1/1", rd_data_w, rd_data_s); else n_pass++;
        wr(A_OVF, 32'h1);
        n_checks++; if (ovf_w !== 4'd0 || ovf_s !== 4'd0) $display("FAIL ovf_w1c got w=%0h s=%0h want 0/0", ovf_w, ovf_s); else n_pass++;
        event_i = 4'b0001;
        tick(1);
        n_checks++; if (ovf_s !== 4'b0001) $display("FAIL sat_reovf got %0h want 1", ovf_s); else n_pass++;
        wbe = 4'hf; addr = A_OVF; wdata = 32'h1;
        tick(1);
        wbe = 4'h0; event_i = 4'b0000;
        n_checks++; if (ovf_s !== 4'b0001) $display("FAIL w1c_vs_set got %0h want 1", ovf_s); else n_pass++;
        n_checks++; if (ovf_w !== 4'b0000) $display("FAIL w1c_no_set got %0h want 0", ovf_w); else n_pass++;
        rd(A_CNT0);
        n_checks++; if (rd_data_w !== 32'd6 || rd_data_s !== 32'd15) $display("FAIL post_w1c_cnt got w=%0d s=%0d want 6/15", rd_data_w, rd_data_s); else n_pass++;
    endtask

    task automatic test_snapshot();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        event_i = 4'b0001;
        tick(7);
        wr(A_SNAP, 32'h0);
        tick(4);
        event_i = 4'b0000;
`ifdef PERF_CNT_SNAPSHOT_EN
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd7) $display("FAIL snap_shadow got %0d want 7", rd_data); else n_pass++;
        rd(A_LIVE0);
        n_checks++; if (rd_data !== 32'd12) $display("FAIL snap_live got %0d want 12", rd_data); else n_pass++;
        rd(A_CNT0 + 32'h4);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL snap_shadow1 got %0d want 0", rd_data); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (rd_data !== 32'd0) $display("FAIL snap_rst_rd got %0d want 0", rd_data); else n_pass++;
        tick(1);
        rst = 1'b0;
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL snap_rst_shadow got %0d want 0", rd_data); else n_pass++;
        rd(A_LIVE0);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL snap_rst_live got %0d want 0", rd_data); else n_pass++;
`else
        rd(A_CNT0);
        n_checks++; if (rd_data !== 32'd12) $display("FAIL nosnap_live got %0d want 12", rd_data); else n_pass++;
        rd(A_LIVE0);
        n_checks++; if (rd_data !== 32'd0) $display("FAIL nosnap_0x60 got %0d want 0", rd_data); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_cycle_count();
        test_legacy_clear();
        test_async_reset();
        test_clear_vs_inc();
        test_freeze();
        test_overflow();
        test_snapshot();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
